// File: rtl/fft_r2_pkg.sv
// Shared types and helpers for the radix-2 FFT datapath:
// write-back FSM encoding, twiddle addressing, complex word helpers.
package fft_r2_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WR_A = 2'd1,
        WB_WR_B = 2'd2
    } wb_state_t;

    // Twiddle index of a butterfly: low (bw-1-stage) bits of A, scaled up by stage.
    function automatic logic [31:0] tw_addr(
        input logic [31:0] idx,
        input int          stage,
        input int          bw
    );
        logic [31:0] mask;
        if (stage >= bw - 1) return '0;
        mask = (32'd1 << (bw - 1 - stage)) - 32'd1;
        return (idx & mask) << stage;
    endfunction

    function automatic logic [63:0] cplx_pack(
        input logic [31:0] re,
        input logic [31:0] im,
        input int          dw
    );
        logic [63:0] m;
        m = (64'd1 << (dw / 2)) - 64'd1;
        return ((64'(re) & m) << (dw / 2)) | (64'(im) & m);
    endfunction

    // Halve re and im of a packed word independently, keeping each sign.
    function automatic logic [63:0] cplx_half(
        input logic [63:0] w,
        input int          dw
    );
        logic [63:0] sh;
        logic [63:0] tops;
        sh   = w >> 1;
        tops = (64'd1 << (dw / 2 - 1)) | (64'd1 << (dw - 1));
        return (sh & ~tops) | (w & tops);
    endfunction

endpackage

// File: rtl/fft_wb_fifo.sv
// Synchronous FIFO holding butterfly address pairs in flight.
// Overflow and underflow requests are ignored; clear empties it.
module fft_wb_fifo
    import fft_r2_pkg::*;
#(
    parameter int W    = 8,
    parameter int LOG2 = 3
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LOG2:0] count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0]    mem [DEPTH];
    logic [LOG2-1:0] wp;
    logic [LOG2-1:0] rp;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rp];

    always_ff @(posedge Clock) begin
        if (do_push && !clear) mem[wp] <= wdata;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (LOG2 + 1)'(do_push)
                           - (LOG2 + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/fft_wb_r2.sv
// Radix-2 FFT read pairing and write-back sequencer.
// Optional FFT_WB_SCALE_EN halves re/im on write-back.
module fft_wb_r2
    import fft_r2_pkg::*;
#(
    parameter int BW_FFTP   = 4,
    parameter int BW_STAGE  = 2,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic                IdxValid,
    input  logic [BW_FFTP-1:0]  Index,
    input  logic [BW_STAGE-1:0] Stage,
    input  logic                IdxEnd,
    input  logic [DATA_W-1:0]   RdData,
    output logic                BfValid,
    output logic [DATA_W-1:0]   BfA,
    output logic [DATA_W-1:0]   BfB,
    output logic [BW_FFTP-2:0]  TwAddr,
    input  logic                BfOutValid,
    input  logic [DATA_W-1:0]   BfOutA,
    input  logic [DATA_W-1:0]   BfOutB,
    output logic                WrEn,
    output logic [BW_FFTP-1:0]  WrAddr,
    output logic [DATA_W-1:0]   WrData,
    output logic                Done,
    output logic                Err
);
    localparam int TW_W = BW_FFTP - 1;
    localparam int PW   = 2 * BW_FFTP;

    logic                             phase;
    logic [RD_LAT-1:0]                p_vld;
    logic [RD_LAT-1:0]                p_isb;
    logic [RD_LAT-1:0][BW_FFTP-1:0]   p_idx;
    logic [RD_LAT-1:0][BW_STAGE-1:0]  p_stg;
    logic                             out_v;
    logic                             out_b;
    logic [BW_FFTP-1:0]               out_i;
    logic [BW_STAGE-1:0]              out_s;

    logic                half;
    logic [DATA_W-1:0]   lat_a;
    logic [BW_FFTP-1:0]  lat_ia;
    logic [BW_STAGE-1:0] lat_st;
    logic                pair_b;
    logic                push;

    logic                full;
    logic                empty;
    logic [FIFO_LOG2:0]  count;
    logic [PW-1:0]       head;

    wb_state_t          state;
    wb_state_t          nxt;
    logic               pop;
    logic               err_wb;
    logic [DATA_W-1:0]  res_a;
    logic [DATA_W-1:0]  res_b;
    logic [BW_FFTP-1:0] addr_a;
    logic [BW_FFTP-1:0] addr_b;
    logic [DATA_W-1:0]  data_a;
    logic [DATA_W-1:0]  data_b;

    logic pend;
    logic done_c;

    assign out_v  = p_vld[RD_LAT-1];
    assign out_b  = p_isb[RD_LAT-1];
    assign out_i  = p_idx[RD_LAT-1];
    assign out_s  = p_stg[RD_LAT-1];
    assign pair_b = out_v & out_b & half;
    assign push   = pair_b & ~full;

    // Index tags travel alongside the RAM so they line up with RdData.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            phase   <= 1'b0;
            p_vld   <= '0;
            p_isb   <= '0;
            p_idx   <= '0;
            p_stg   <= '0;
            half    <= 1'b0;
            lat_a   <= '0;
            lat_ia  <= '0;
            lat_st  <= '0;
            BfValid <= 1'b0;
            BfA     <= '0;
            BfB     <= '0;
            TwAddr  <= '0;
        end else if (Start) begin
            phase   <= 1'b0;
            p_vld   <= '0;
            half    <= 1'b0;
            BfValid <= 1'b0;
        end else begin
            p_vld[0] <= IdxValid;
            p_isb[0] <= phase;
            p_idx[0] <= Index;
            p_stg[0] <= Stage;
            for (int i = 1; i < RD_LAT; i++) begin
                p_vld[i] <= p_vld[i-1];
                p_isb[i] <= p_isb[i-1];
                p_idx[i] <= p_idx[i-1];
                p_stg[i] <= p_stg[i-1];
            end
            if (IdxValid) phase <= ~phase;
            BfValid <= 1'b0;
            if (out_v && !out_b) begin
                half   <= 1'b1;
                lat_a  <= RdData;
                lat_ia <= out_i;
                lat_st <= out_s;
            end else if (pair_b) begin
                half <= 1'b0;
                // A pair that cannot be queued is dropped entirely.
                if (!full) begin
                    BfValid <= 1'b1;
                    BfA     <= lat_a;
                    BfB     <= RdData;
                    TwAddr  <= TW_W'(tw_addr(32'(lat_ia),
                                             int'(lat_st),
                                             BW_FFTP));
                end
            end
        end
    end

    fft_wb_fifo #(
        .W    (PW),
        .LOG2 (FIFO_LOG2)
    ) u_fifo (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clear   (Start),
        .push    (push),
        .pop     (pop),
        .wdata   ({lat_ia, out_i}),
        .rdata   (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        nxt    = state;
        pop    = 1'b0;
        err_wb = 1'b0;
        unique case (state)
            WB_IDLE: begin
                if (BfOutValid) begin
                    if (!empty) begin
                        pop = 1'b1;
                        nxt = WB_WR_A;
                    end else begin
                        err_wb = 1'b1;
                    end
                end
            end
            WB_WR_A: begin
                err_wb = BfOutValid;
                nxt    = WB_WR_B;
            end
            WB_WR_B: begin
                if (BfOutValid && !empty) begin
                    pop = 1'b1;
                    nxt = WB_WR_A;
                end else begin
                    err_wb = BfOutValid;
                    nxt    = WB_IDLE;
                end
            end
            default: nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= WB_IDLE;
            res_a  <= '0;
            res_b  <= '0;
            addr_a <= '0;
            addr_b <= '0;
        end else if (Start) begin
            state <= WB_IDLE;
        end else begin
            state <= nxt;
            if (pop) begin
                res_a  <= BfOutA;
                res_b  <= BfOutB;
                addr_a <= head[PW-1:BW_FFTP];
                addr_b <= head[BW_FFTP-1:0];
            end
        end
    end

`ifdef FFT_WB_SCALE_EN
    assign data_a = DATA_W'(cplx_half(64'(res_a), DATA_W));
    assign data_b = DATA_W'(cplx_half(64'(res_b), DATA_W));
`else
    assign data_a = res_a;
    assign data_b = res_b;
`endif

    always_comb begin
        WrEn   = 1'b0;
        WrAddr = '0;
        WrData = '0;
        unique case (state)
            WB_WR_A: begin
                WrEn   = 1'b1;
                WrAddr = addr_a;
                WrData = data_a;
            end
            WB_WR_B: begin
                WrEn   = 1'b1;
                WrAddr = addr_b;
                WrData = data_b;
            end
            default: ;
        endcase
    end

    assign done_c = pend & (p_vld == '0) & ~half
                  & (count == '0) & (state == WB_IDLE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Err  <= 1'b0;
            pend <= 1'b0;
            Done <= 1'b0;
        end else if (Start) begin
            Err  <= 1'b0;
            pend <= 1'b0;
            Done <= 1'b0;
        end else begin
            if (err_wb || (pair_b && full)) Err <= 1'b1;
            Done <= done_c;
            pend <= IdxEnd | (pend & ~done_c);
        end
    end

endmodule

// File: doc/fft_wb_r2.md
# fft_wb_r2

Radix-2 FFT read-data pairing and write-back sequencer: the consumer end of the A/B index stream produced by the FFT index generator. Per pair it collects RAM read data for index A then index B, issues one butterfly operand pair with its twiddle ROM address, and queues the two indices. When the butterfly result returns, it writes A then B back to the same RAM addresses, then pulses Done after the final pair of the transform.

## Interface
- BW_FFTP, 4: index width; N = 2^BW_FFTP points
- BW_STAGE, 2: stage field width, must hold BW_FFTP
- DATA_W, 32: packed complex word {re, im}, each DATA_W/2 signed
- RD_LAT, 1: RAM read latency in cycles, at least 1
- FIFO_LOG2, 3: address FIFO depth is 2^FIFO_LOG2 pairs

Ports:
- Clock  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; clears FIFO, Err, pending-done
- IdxValid  in  1  Index/Stage valid this cycle; A and B alternate, A first
- Index  in  BW_FFTP  RAM read address, also driven to RAM
- Stage  in  BW_STAGE  stage of the current index
- IdxEnd  in  1  one-cycle pulse: index stream finished
- RdData  in  DATA_W  RAM read data, RD_LAT cycles after Index
- BfValid  out  1  operand pair valid (one cycle)
- BfA, BfB  out  DATA_W  operands for A and B
- TwAddr  out  BW_FFTP-1  twiddle ROM address
- BfOutValid  in  1  butterfly result valid
- BfOutA, BfOutB  in  DATA_W  results
- WrEn  out  1  RAM write strobe
- WrAddr  out  BW_FFTP  RAM write address
- WrData  out  DATA_W  RAM write data
- Done  out  1  one-cycle completion pulse
- Err  out  1  sticky protocol error

## Operation
- Read pipeline: a shift register of depth RD_LAT carries {IdxValid, A/B phase, Index, Stage}. Phase toggles on each IdxValid, and Start forces the next index to be A.
- Pair assembly: when the pipeline output is phase A, latch RdData, IndexA and Stage. On phase B, register BfA (latched), BfB (RdData) and TwAddr, and assert BfValid for one cycle.
- Twiddle: TwAddr = (IndexA & (2^(BW_FFTP-1-Stage) - 1)) << Stage, truncated to BW_FFTP-1 bits.
- FIFO: push {IndexA, IndexB} in the same cycle BfValid asserts. Pop on BfOutValid.
- Write-back FSM has three states: IDLE, WR_A, WR_B.
  - IDLE: if BfOutValid and the FIFO is not empty, pop, latch results, go to WR_A.
  - WR_A: WrEn=1, WrAddr=IndexA, WrData=OutA; go to WR_B.
  - WR_B: WrEn=1, WrAddr=IndexB, WrData=OutB. Go to WR_A if BfOutValid is present again (pop), else IDLE.
- Done:
  - IdxEnd sets pending.
  - Done pulses for one cycle when pending is set, the read pipeline is empty, no pair is half-assembled, the FIFO is empty and the FSM is IDLE. Pending clears at the same time.

## Timing
- Reset values: BfValid, WrEn, Done and Err are 0. BfA, BfB, TwAddr, WrAddr and WrData are 0. The FIFO is empty and the FSM is IDLE.
- Index A presented at cycle t gives BfValid at t+RD_LAT+2. BfOutValid at cycle u gives the A write at u+1 and the B write at u+2.
- BfOutValid on consecutive cycles is legal only from WR_B; otherwise it is a protocol error.
- Error conditions:
  - BfOutValid with an empty FIFO: set Err, ignore the result.
  - Push into a full FIFO: set Err, drop the pair.
  - BfOutValid in WR_A: set Err, ignore.
- Push and pop in the same cycle are both honoured; the count is unchanged.
- Start mid-operation flushes the read pipeline, FIFO and FSM in the next cycle. Writes in progress are abandoned.
- Reset_n is asynchronous and clears all state mid-operation.
- The block never stalls upstream; read-after-write hazards across stages are upstream's responsibility.

## Configuration
- FFT_WB_SCALE_EN defined: WrData re and im are each shifted arithmetically right by 1 (floor) on write-back, giving a per-stage block scale of 1/2.
- FFT_WB_SCALE_EN undefined: results are written unmodified.

## Structure
- Shared package `fft_r2_pkg`: complex packing helpers, twiddle address function, FSM state encoding.
- One sub-module `fft_wb_fifo`: synchronous FIFO with count, full/empty flags and a clear input.

## Test plan
1. Reset, then BW_FFTP=4, RD_LAT=1, index pair A=0, B=8 at stage 0, RdData 0x11/0x22. Required: BfValid with BfA=0x11, BfB=0x22, TwAddr=0.
2. Pair A=5, B=7 at stage 2. Required: TwAddr=(5&1)<<2=4.
3. BfOutValid with OutA=0xAAAA0000, OutB=0x0000BBBB after pair 0/8:
   - Required: WrAddr 0 then 8 on consecutive cycles.
   - Without FFT_WB_SCALE_EN, data is unchanged.
   - With FFT_WB_SCALE_EN, WrData re/im are halved with sign preserved.
4. Full 4-stage stream of 32 pairs plus IdxEnd, with the butterfly modelled at 3-cycle latency. Required: 64 writes, a single Done pulse after the last B write, Err=0.
5. BfOutValid with an empty FIFO. Required: Err=1 held and no WrEn. Then Start: Required: Err=0.
6. Reset_n low during WR_A. Required: WrEn=0 immediately and the FIFO empty after release.
